// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite animation controller.
//   anim_state_t : draw-control FSM states
//   DONE_BLANK   : cycles after a draw starts during which the drawer's
//                  done flag is ignored (it is still high from the last draw)
//   cnt_width()  : width of a counter/index holding 0..n-1, never below 1 bit
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DRAWING,
    ABORT
  } anim_state_t;

  localparam int DONE_BLANK = 3;
  localparam int BLANK_W    = $clog2(DONE_BLANK + 1);

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// Handshake bundle between the animation controller and the sprite line drawer.
//   start     : one-cycle start pulse to the drawer
//   spr_rst_n : active-low reset to the drawer
//   rom_addr  : graphic ROM address for the current frame and pixel
//   pos       : in-frame pixel position from the drawer
//   done      : drawer completion flag
// modport master = controller side, modport slave = drawer side.
interface sprite_anim_ctrl_if #(
  parameter int ADDRW  = 6,
  parameter int FRAMES = 4
);
  import sprite_pkg::*;

  localparam int ROM_ADDRW = ADDRW + $clog2(FRAMES);

  logic                 start;
  logic                 spr_rst_n;
  logic [ROM_ADDRW-1:0] rom_addr;
  logic [ADDRW-1:0]     pos;
  logic                 done;

  modport master (
    output start, spr_rst_n, rom_addr,
    input  pos, done
  );

  modport slave (
    input  start, spr_rst_n, rom_addr,
    output pos, done
  );

endinterface

// File: rtl/sprite_anim_timer.sv
// Animation timer: counts video frames and steps the animation frame index
// once every FRAME_TICKS frames while i_play is high.
// Build option: SPRITE_ANIM_PINGPONG_EN makes the index bounce between 0 and
// FRAMES-1 instead of wrapping (FRAMES<=2 always wraps).
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_frame        : one-cycle pulse per video frame
//   i_play         : 1 = animate, 0 = hold tick and frame
//   o_frame_idx    : current animation frame (registered)
module sprite_anim_timer
  import sprite_pkg::*;
#(
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_frame,
  input  logic                             i_play,
  output logic [cnt_width(FRAMES)-1:0]     o_frame_idx
);

  localparam int FIW   = cnt_width(FRAMES);
  localparam int TICKW = cnt_width(FRAME_TICKS);
  localparam logic [FIW-1:0]   IDX_LAST  = FIW'(FRAMES - 1);
  localparam logic [TICKW-1:0] TICK_LAST = TICKW'(FRAME_TICKS - 1);

  logic [TICKW-1:0] tick_reg, tick_next;
  logic [FIW-1:0]   idx_reg, idx_next;
`ifdef SPRITE_ANIM_PINGPONG_EN
  logic             dir_down_reg, dir_down_next;
`endif

  always_comb begin
    tick_next = tick_reg;
    idx_next  = idx_reg;
`ifdef SPRITE_ANIM_PINGPONG_EN
    dir_down_next = dir_down_reg;
`endif
    if (i_frame && i_play) begin
      if (tick_reg == TICK_LAST) begin
        tick_next = '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
        if (FRAMES <= 2) begin
          idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else if (!dir_down_reg) begin
          if (idx_reg == IDX_LAST) begin
            dir_down_next = 1'b1;
            idx_next      = idx_reg - 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          if (idx_reg == '0) begin
            dir_down_next = 1'b0;
            idx_next      = idx_reg + 1'b1;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end
`else
        // With FRAMES==1 IDX_LAST is 0, so the index stays at 0.
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
`endif
      end else begin
        tick_next = tick_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tick_reg <= '0;
      idx_reg  <= '0;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_down_reg <= 1'b0;
`endif
    end else begin
      tick_reg <= tick_next;
      idx_reg  <= idx_next;
`ifdef SPRITE_ANIM_PINGPONG_EN
      dir_down_reg <= dir_down_next;
`endif
    end
  end

  assign o_frame_idx = idx_reg;

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation controller: starts the sprite line drawer on the sprite's
// top scanline, aborts a draw still running when the video frame ends, steps
// the animation frame and maps the drawer's pixel position to a ROM address.
// Build option: SPRITE_ANIM_PINGPONG_EN (ping-pong frame order, see timer).
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_line         : pulse at the start of each scanline
//   i_frame        : pulse at the start of vertical blanking
//   i_sy           : current screen line (signed)
//   i_spry         : sprite top line (signed), used only with i_line
//   i_play         : 1 = animate, 0 = hold frame
//   o_frame_idx    : current animation frame
//   o_busy         : a draw is outstanding
//   drw            : drawer handshake (start, spr_rst_n, rom_addr, pos, done)
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8,
  parameter int CORDW       = 16,
  parameter int ADDRW       = 6
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_line,
  input  logic                          i_frame,
  input  logic signed [CORDW-1:0]       i_sy,
  input  logic signed [CORDW-1:0]       i_spry,
  input  logic                          i_play,
  output logic [cnt_width(FRAMES)-1:0]  o_frame_idx,
  output logic                          o_busy,
  sprite_anim_ctrl_if.master            drw
);

  localparam int ROM_ADDRW  = ADDRW + $clog2(FRAMES);
  localparam int SPR_PIX    = WIDTH * HEIGHT;
  // Sprites whose bottom would pass the largest positive line are never drawn.
  localparam int SPRY_LIMIT = (1 << (CORDW - 1)) - HEIGHT;

  anim_state_t        state_reg, state_next;
  logic [BLANK_W-1:0] blank_reg, blank_next;
  logic               start_reg, busy_reg, spr_rst_n_reg;
  logic               spry_ok;

  always_comb begin
    spry_ok = (int'(i_spry) >= 0) && (int'(i_spry) < SPRY_LIMIT);
  end

  always_comb begin
    state_next = state_reg;
    blank_next = blank_reg;
    case (state_reg)
      IDLE: begin
        if (i_line && (i_sy == i_spry) && spry_ok) state_next = START;
      end
      START: begin
        state_next = DRAWING;
        blank_next = '0;
      end
      DRAWING: begin
        // End of frame wins over completion: the frame index may change now.
        if (i_frame) begin
          state_next = ABORT;
        end else if (blank_reg != BLANK_W'(DONE_BLANK)) begin
          blank_next = blank_reg + 1'b1;
        end else if (drw.done) begin
          state_next = IDLE;
        end
      end
      ABORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered decodes of the current state, so each one lags
  // its state by a cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      blank_reg     <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      spr_rst_n_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      blank_reg     <= blank_next;
      start_reg     <= (state_reg == START);
      busy_reg      <= (state_reg != IDLE);
      spr_rst_n_reg <= (state_reg != ABORT);
    end
  end

  sprite_anim_timer #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame     (i_frame),
    .i_play      (i_play),
    .o_frame_idx (o_frame_idx)
  );

  // Combinational on purpose: the drawer already allows for ROM read latency.
  assign drw.rom_addr  = ROM_ADDRW'(o_frame_idx) * ROM_ADDRW'(SPR_PIX)
                       + ROM_ADDRW'(drw.pos);
  assign drw.start     = start_reg;
  assign drw.spr_rst_n = spr_rst_n_reg;
  assign o_busy        = busy_reg;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
module tb_sprite_anim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, line, frame, play;
  logic signed [15:0] sy, spry;
  logic [1:0]         frame_idx;
  logic               busy;
  int                 errors = 0;
  int                 checks = 0;

  sprite_anim_ctrl_if #(.ADDRW(6), .FRAMES(4)) drw ();

  sprite_anim_ctrl #(
    .WIDTH(8), .HEIGHT(8), .FRAMES(4), .FRAME_TICKS(2), .CORDW(16), .ADDRW(6)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_line      (line),
    .i_frame     (frame),
    .i_sy        (sy),
    .i_spry      (spry),
    .i_play      (play),
    .o_frame_idx (frame_idx),
    .o_busy      (busy),
    .drw         (drw)
  );

`ifdef SPRITE_ANIM_PINGPONG_EN
  localparam int NPULSE = 8;
  int exp_seq [13] = '{0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
`else
  localparam int NPULSE = 12;
  int exp_seq [13] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=%0d expected=%0d ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    step();
    frame = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; line = 1'b0; frame = 1'b0; play = 1'b0;
    sy = 16'sd0; spry = 16'sd10; drw.pos = '0; drw.done = 1'b0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_start", drw.start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame", frame_idx, 0);
      chk("rst_spr_rst_n", drw.spr_rst_n, 0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_spr_rst_n", drw.spr_rst_n, 1);
    chk("post_rst_busy", busy, 0);

    // Wrong line: no start
    sy = 16'sd9; line = 1'b1; step(); line = 1'b0; step();
    chk("sy9_start", drw.start, 0);
    chk("sy9_busy", busy, 0);

    // Matching line: start two cycles after the line pulse, one cycle wide
    sy = 16'sd10; line = 1'b1; step(); line = 1'b0;
    chk("start_early", drw.start, 0);
    step();
    chk("start_pulse", drw.start, 1);
    chk("start_busy", busy, 1);
    step();
    chk("start_one_cycle", drw.start, 0);
    repeat (3) step();
    drw.done = 1'b1; step(); drw.done = 1'b0;
    chk("done_busy_lag", busy, 1);
    step();
    chk("done_busy_drop", busy, 0);

    // Stale done held high: three blank cycles before it is honoured
    drw.done = 1'b1; line = 1'b1; step(); line = 1'b0;
    step();
    chk("stale_start", drw.start, 1);
    repeat (4) step();
    chk("stale_blank_busy", busy, 1);
    step();
    chk("stale_idle_busy", busy, 0);
    drw.done = 1'b0;

    // Clipping boundaries
    spry = -16'sd3; sy = -16'sd3; line = 1'b1; step(); line = 1'b0; step();
    chk("clip_neg_busy", busy, 0);
    spry = 16'sd32760; sy = 16'sd32760; line = 1'b1; step(); line = 1'b0; step();
    chk("clip_bottom_busy", busy, 0);
    spry = 16'sd32759; sy = 16'sd32759; line = 1'b1; step(); line = 1'b0; step();
    chk("clip_last_ok_start", drw.start, 1);
    drw.done = 1'b1;
    repeat (6) step();
    drw.done = 1'b0;
    chk("clip_last_ok_idle", busy, 0);

    // Animation sequence with play on
    play = 1'b1;
    for (int n = 0; n < NPULSE; n++) begin
      chk($sformatf("anim_seq%0d", n), frame_idx, exp_seq[n]);
      frame_pulse();
    end
    chk("anim_end", frame_idx, exp_seq[NPULSE]);

    // Address at frame 2
    drw.pos = 6'd5; #1;
    chk("addr_f2_p5", drw.rom_addr, 133);
    drw.pos = 6'd63; #1;
    chk("addr_f2_p63", drw.rom_addr, 191);
    drw.pos = 6'd0;

    // Hold with play off
    play = 1'b0;
    for (int n = 0; n < 4; n++) begin
      frame_pulse();
      chk($sformatf("hold%0d", n), frame_idx, 2);
    end

    // Abort: end of frame and done together while drawing
    spry = 16'sd475; sy = 16'sd475; line = 1'b1; step(); line = 1'b0;
    step();
    chk("abort_start", drw.start, 1);
    repeat (3) step();
    frame = 1'b1; drw.done = 1'b1; step(); frame = 1'b0; drw.done = 1'b0;
    chk("abort_spr_rst_pre", drw.spr_rst_n, 1);
    step();
    chk("abort_spr_rst_low", drw.spr_rst_n, 0);
    chk("abort_busy", busy, 1);
    step();
    chk("abort_spr_rst_back", drw.spr_rst_n, 1);
    chk("abort_idle_busy", busy, 0);
    chk("abort_frame_held", frame_idx, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
